alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one `simple_alu` instance between two requesters, for example the UART command path and a local test/stimulus port. It accepts one operand/opcode triple at a time with a valid/ready handshake and drives the ALU operand bus from registers. It captures result and flags one cycle later, then returns them to the granted requester with a second valid/ready handshake. It sits between the requesters and the ALU and replaces the direct register-to-ALU connection.

## Interface
- `DATA_WIDTH`, 8, width of A, B and the result.
- `OP_WIDTH`, 6, opcode width.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready[1:0]`  out  2  per-requester request accepted this cycle when `valid&ready`.
- `req_a0`, `req_b0` / `req_a1`, `req_b1`  in  DATA_WIDTH each  operands for requesters 0 and 1.
- `req_op0` / `req_op1`  in  OP_WIDTH  opcodes for requesters 0 and 1.
- `rsp_valid[1:0]`  out  2  response valid, one-hot, only to the granted requester.
- `rsp_ready[1:0]`  in  2  response consumed.
- `rsp_result`  out  DATA_WIDTH  captured result; shared bus, qualified by `rsp_valid`.
- `rsp_zero`, `rsp_overflow`  out  1  captured flags; shared.
- `alu_a`, `alu_b`  out  DATA_WIDTH  registered operands to the ALU.
- `alu_op`  out  OP_WIDTH  registered opcode to the ALU.
- `alu_result`  in  DATA_WIDTH  combinational ALU result.
- `alu_zero`, `alu_overflow`  in  1  combinational ALU flags.
- `busy`  out  1  high in EXEC and RESP.
- `grant_id`  out  1  requester currently or last served.
- `op_count`  out  16  completed transactions; wraps at 0xFFFF→0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration is combinational over `req_valid`.
  - If only one requester is valid, it wins.
  - If both are valid, the requester ≠ `last_grant` wins.
  - `req_ready` is high for the winner only. It is never high outside IDLE, and never high when no request is valid.
- Accept (IDLE and `req_valid[w]&req_ready[w]`):
  - Register that requester's A/B/Op into `alu_a/alu_b/alu_op`.
  - `grant_id←w`, `last_grant←w`, go to EXEC.
- EXEC (one cycle): the ALU settles on the registered operands. At the end of the cycle, capture `alu_result/zero/overflow` into the `rsp_*` registers and go to RESP.
- RESP:
  - `rsp_valid[grant_id]` is high and the `rsp_*` outputs are stable.
  - On `rsp_ready[grant_id]`: go to IDLE and increment `op_count`.
  - `rsp_ready` from the non-granted requester is ignored.
- `alu_a/b/op` hold their last values after a transaction. The ALU output stays valid, matching the existing register behaviour.
- Requesters must hold A/B/Op stable while valid; they are sampled only on the accept cycle.
- A request arriving during EXEC or RESP waits and is arbitrated on return to IDLE.
- Reset state:
  - State IDLE, `last_grant=1` (requester 0 wins the first tie).
  - `grant_id=0`, `op_count=0`.
  - All `alu_*` and `rsp_*` registers 0; `busy=0`.
  - `req_ready=0` and `rsp_valid=0` while `reset_n=0`.
- Reset asserted mid-transaction: asynchronous clear to the reset state. The in-flight response is dropped, `op_count` is not incremented, and the requester must reissue.

## Timing
- Accept in cycle T:
  - EXEC in T+1 (`alu_*` outputs hold the new values from the T+1 edge).
  - RESP with `rsp_valid` high from T+2.
- If `rsp_ready` is high in T+2: IDLE in T+3, and the earliest next accept is T+3.
- Sustained throughput: one operation per 3 cycles.
- `rsp_valid` stays asserted indefinitely until `rsp_ready`; there is no timeout.
- `busy` is a registered function of state: high T+1 through the RESP exit cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…; no requester waits more than one foreign transaction.

## Test plan
- Reset, then only requester 0 requests A=0x05, B=0x03, Op=ADD:
  - `req_ready[0]` in the same cycle.
  - `alu_a=0x05`, `alu_b=0x03` at T+1.
  - `rsp_valid[0]`, `rsp_result=0x08`, zero=0, overflow=0 at T+2.
  - `op_count=1` after `rsp_ready[0]`.
- Both requesters valid continuously with distinct operands: grants 0,1,0,1 over four transactions; each response carries its own requester's result; `op_count=4`.
- Requester 1 keeps `rsp_ready[1]=0` for 10 cycles in RESP:
  - `rsp_valid[1]` and the result stay stable.
  - A requester 0 request is not accepted until cycle 1 after the handshake.
- Op=SUB with A=0x80, B=0x01: `rsp_overflow=1`, `rsp_result=0x7F`. A=B=0x2A SUB: `rsp_zero=1`.
- `reset_n` pulsed low during EXEC and again during RESP:
  - Outputs go to reset values immediately (asynchronously).
  - `op_count` is unchanged from 0.
  - A new request after release completes normally.
- `op_count` preloaded by running 65536 transactions (or forced at 0xFFFF): the next completion wraps it to 0x0000.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
// Requesters drive the master side, the arbiter takes the slave side.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [DATA_WIDTH-1:0] req_a0;
    logic [DATA_WIDTH-1:0] req_b0;
    logic [DATA_WIDTH-1:0] req_a1;
    logic [DATA_WIDTH-1:0] req_b1;
    logic [OP_WIDTH-1:0]   req_op0;
    logic [OP_WIDTH-1:0]   req_op1;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_zero;
    logic                  rsp_overflow;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation every three cycles: accept (IDLE), settle (EXEC), hand back (RESP).
module alu_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_arbiter_if.slave          bus,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    output logic                  busy,
    output logic                  grant_id,
    output logic [15:0]           op_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state;
    logic                  last_grant;
    logic                  win;
    logic                  accept;
    logic [15:0]           op_cnt;
    logic [DATA_WIDTH-1:0] rsp_result_q;
    logic                  rsp_zero_q;
    logic                  rsp_overflow_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        win = 1'b0;
        if (bus.req_valid == 2'b11)
            win = ~last_grant;
        else
            win = bus.req_valid[1];
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (reset_n && state == S_IDLE && |bus.req_valid)
            bus.req_ready = win ? 2'b10 : 2'b01;
    end

    assign accept = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            last_grant     <= 1'b1;
            grant_id       <= 1'b0;
            op_cnt         <= 16'd0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_a      <= win ? bus.req_a1  : bus.req_a0;
                        alu_b      <= win ? bus.req_b1  : bus.req_b0;
                        alu_op     <= win ? bus.req_op1 : bus.req_op0;
                        grant_id   <= win;
                        last_grant <= win;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result_q   <= alu_result;
                    rsp_zero_q     <= alu_zero;
                    rsp_overflow_q <= alu_overflow;
                    state          <= S_RESP;
                end
                S_RESP: begin
                    // Only the granted requester can retire the response.
                    if (bus.rsp_ready[grant_id]) begin
                        op_cnt <= op_cnt + 16'd1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rsp_valid = 2'b00;
        if (state == S_RESP)
            bus.rsp_valid = grant_id ? 2'b10 : 2'b01;
    end

    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign busy             = (state != S_IDLE);
    assign op_count         = op_cnt;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU (ADD/SUB).
module tb_alu_arbiter;
    localparam int DW = 8;
    localparam int OW = 6;
    localparam logic [OW-1:0] OP_ADD = 6'h00;
    localparam logic [OW-1:0] OP_SUB = 6'h01;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [OW-1:0] alu_op;
    logic          alu_zero, alu_overflow;
    logic          busy, grant_id;
    logic [15:0]   op_count;

    int checks = 0;
    int failures = 0;

    alu_arbiter_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus_if ();

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus_if.slave),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .busy         (busy),
        .grant_id     (grant_id),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            OP_SUB: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus_if.req_valid = 2'b01;
        bus_if.rsp_ready = 2'b00;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_if.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", bus_if.req_ready); end
        checks++;
        if (bus_if.rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", bus_if.rsp_valid); end
        checks++;
        if ({busy, grant_id, op_count} !== 18'd0) begin failures++; $display("FAIL reset_status got busy=%b gid=%b cnt=%h exp 0", busy, grant_id, op_count); end
        checks++;
        if ({alu_a, alu_b, alu_op, bus_if.rsp_result} !== '0) begin failures++; $display("FAIL reset_regs got a=%h b=%h op=%h r=%h exp 0", alu_a, alu_b, alu_op, bus_if.rsp_result); end
        bus_if.req_valid = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        bus_if.req_a0 = 8'h05; bus_if.req_b0 = 8'h03; bus_if.req_op0 = OP_ADD;
        bus_if.req_valid = 2'b01;
        #1;
        checks++;
        if (bus_if.req_ready !== 2'b01) begin failures++; $display("FAIL add_req_ready got=%b exp=01", bus_if.req_ready); end
        @(negedge clk);
        bus_if.req_valid = 2'b00;
        checks++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03 || busy !== 1'b1) begin failures++; $display("FAIL add_exec got a=%h b=%h busy=%b exp 05 03 1", alu_a, alu_b, busy); end
        @(negedge clk);
        checks++;
        if (bus_if.rsp_valid !== 2'b01 || bus_if.rsp_result !== 8'h08 || bus_if.rsp_zero !== 1'b0 || bus_if.rsp_overflow !== 1'b0) begin
            failures++; $display("FAIL add_rsp got v=%b r=%h z=%b o=%b exp 01 08 0 0", bus_if.rsp_valid, bus_if.rsp_result, bus_if.rsp_zero, bus_if.rsp_overflow);
        end
        bus_if.rsp_ready = 2'b01;
        @(negedge clk);
        bus_if.rsp_ready = 2'b00;
        checks++;
        if (op_count !== 16'd1 || busy !== 1'b0) begin failures++; $display("FAIL add_count got cnt=%0d busy=%b exp 1 0", op_count, busy); end
    endtask

    task automatic test_fairness();
        logic [1:0]    exp_oh;
        logic [DW-1:0] exp_r;
        do_reset();
        bus_if.req_a0 = 8'h10; bus_if.req_b0 = 8'h01; bus_if.req_op0 = OP_ADD;
        bus_if.req_a1 = 8'h20; bus_if.req_b1 = 8'h02; bus_if.req_op1 = OP_ADD;
        bus_if.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_r  = (i % 2 == 0) ? 8'h11 : 8'h22;
            #1;
            checks++;
            if (bus_if.req_ready !== exp_oh) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, bus_if.req_ready, exp_oh); end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (bus_if.rsp_valid !== exp_oh || bus_if.rsp_result !== exp_r) begin
                failures++; $display("FAIL rr_rsp[%0d] got v=%b r=%h exp v=%b r=%h", i, bus_if.rsp_valid, bus_if.rsp_result, exp_oh, exp_r);
            end
            bus_if.rsp_ready = exp_oh;
            @(negedge clk);
            bus_if.rsp_ready = 2'b00;
        end
        bus_if.req_valid = 2'b00;
        checks++;
        if (op_count !== 16'd4) begin failures++; $display("FAIL rr_count got=%0d exp=4", op_count); end
    endtask

    task automatic test_backpressure();
        // last_grant is 1 here, so requester 1 alone is served.
        @(negedge clk);
        bus_if.req_a1 = 8'h30; bus_if.req_b1 = 8'h03; bus_if.req_op1 = OP_ADD;
        bus_if.req_a0 = 8'h40; bus_if.req_b0 = 8'h04; bus_if.req_op0 = OP_ADD;
        bus_if.req_valid = 2'b10;
        #1;
        checks++;
        if (bus_if.req_ready !== 2'b10) begin failures++; $display("FAIL bp_accept1 got=%b exp=10", bus_if.req_ready); end
        @(negedge clk);
        bus_if.req_valid = 2'b01;
        #1;
        checks++;
        if (bus_if.req_ready !== 2'b00) begin failures++; $display("FAIL bp_exec_ready got=%b exp=00", bus_if.req_ready); end
        @(negedge clk);
        bus_if.rsp_ready = 2'b01;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus_if.rsp_valid !== 2'b10 || bus_if.rsp_result !== 8'h33 || bus_if.req_ready !== 2'b00) begin
                failures++; $display("FAIL bp_hold[%0d] got v=%b r=%h rdy=%b exp 10 33 00", i, bus_if.rsp_valid, bus_if.rsp_result, bus_if.req_ready);
            end
            @(negedge clk);
        end
        bus_if.rsp_ready = 2'b10;
        @(negedge clk);
        bus_if.rsp_ready = 2'b00;
        checks++;
        if (bus_if.req_ready !== 2'b01 || op_count !== 16'd5) begin failures++; $display("FAIL bp_release got rdy=%b cnt=%0d exp 01 5", bus_if.req_ready, op_count); end
        @(negedge clk);
        bus_if.req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (bus_if.rsp_valid !== 2'b01 || bus_if.rsp_result !== 8'h44) begin failures++; $display("FAIL bp_req0 got v=%b r=%h exp 01 44", bus_if.rsp_valid, bus_if.rsp_result); end
        bus_if.rsp_ready = 2'b01;
        @(negedge clk);
        bus_if.rsp_ready = 2'b00;
    endtask

    task automatic test_sub_flags();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_if.req_a0  = (i == 0) ? 8'h80 : 8'h2A;
            bus_if.req_b0  = (i == 0) ? 8'h01 : 8'h2A;
            bus_if.req_op0 = OP_SUB;
            bus_if.req_valid = 2'b01;
            @(negedge clk);
            bus_if.req_valid = 2'b00;
            @(negedge clk);
            checks++;
            if (i == 0 && (bus_if.rsp_result !== 8'h7F || bus_if.rsp_overflow !== 1'b1 || bus_if.rsp_zero !== 1'b0)) begin
                failures++; $display("FAIL sub_ovf got r=%h o=%b z=%b exp 7F 1 0", bus_if.rsp_result, bus_if.rsp_overflow, bus_if.rsp_zero);
            end
            if (i == 1 && (bus_if.rsp_result !== 8'h00 || bus_if.rsp_zero !== 1'b1 || bus_if.rsp_overflow !== 1'b0)) begin
                failures++; $display("FAIL sub_zero got r=%h z=%b o=%b exp 00 1 0", bus_if.rsp_result, bus_if.rsp_zero, bus_if.rsp_overflow);
            end
            bus_if.rsp_ready = 2'b01;
            @(negedge clk);
            bus_if.rsp_ready = 2'b00;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_if.req_a0 = 8'h01; bus_if.req_b0 = 8'h01; bus_if.req_op0 = OP_ADD;
            bus_if.req_valid = 2'b01;
            @(negedge clk);
            bus_if.req_valid = 2'b00;
            if (i == 1) @(negedge clk);
            #2;
            reset_n = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0 || bus_if.rsp_valid !== 2'b00 || alu_a !== 8'h00 || bus_if.rsp_result !== 8'h00 || op_count !== 16'd0) begin
                failures++; $display("FAIL mid_reset[%0d] got busy=%b v=%b a=%h r=%h cnt=%0d exp all 0", i, busy, bus_if.rsp_valid, alu_a, bus_if.rsp_result, op_count);
            end
            @(negedge clk);
            reset_n = 1'b1;
        end
        @(negedge clk);
        bus_if.req_a0 = 8'h07; bus_if.req_b0 = 8'h09; bus_if.req_op0 = OP_ADD;
        bus_if.req_valid = 2'b01;
        @(negedge clk);
        bus_if.req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (bus_if.rsp_valid !== 2'b01 || bus_if.rsp_result !== 8'h10) begin failures++; $display("FAIL mid_after got v=%b r=%h exp 01 10", bus_if.rsp_valid, bus_if.rsp_result); end
        bus_if.rsp_ready = 2'b01;
        @(negedge clk);
        bus_if.rsp_ready = 2'b00;
        checks++;
        if (op_count !== 16'd1) begin failures++; $display("FAIL mid_count got=%0d exp=1", op_count); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_cnt = 16'hFFFF;
        #1;
        release dut.op_cnt;
        @(negedge clk);
        bus_if.req_a0 = 8'h02; bus_if.req_b0 = 8'h02; bus_if.req_op0 = OP_ADD;
        bus_if.req_valid = 2'b01;
        @(negedge clk);
        bus_if.req_valid = 2'b00;
        @(negedge clk);
        bus_if.rsp_ready = 2'b01;
        @(negedge clk);
        bus_if.rsp_ready = 2'b00;
        checks++;
        if (op_count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", op_count); end
    endtask

    initial begin
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 2'b00;
        bus_if.req_a0 = '0; bus_if.req_b0 = '0; bus_if.req_op0 = '0;
        bus_if.req_a1 = '0; bus_if.req_b1 = '0; bus_if.req_op1 = '0;
        test_reset();
        test_single_add();
        test_fairness();
        test_backpressure();
        test_sub_flags();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
